// File: rtl/config_readback_pkg.sv
// Shared definitions for the configuration readback responder:
// FSM state encoding, register index constants and byte-count helpers.
package config_readback_pkg;

    // Readback FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } rb_state_t;

    // Register index constants for the configuration bank.
    localparam int           REG_IDX_W = 3;
    localparam logic [2:0]   REG_FLAGS = 3'd0;

    // Number of bytes in a register of the given width.
    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

    // Width of the byte counter: clog2 of the byte count, at least 1 bit.
    function automatic int cnt_width(input int data_w);
        int n;
        n = byte_count(data_w);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/config_readback_byte_mux.sv
// readback_byte_mux: selects one byte of the frozen snapshot and, when
// READBACK_CSUM_EN is defined, forms the XOR of all snapshot bytes.
import config_readback_pkg::*;

module readback_byte_mux #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = cnt_width(DATA_W)
) (
    input  logic [DATA_W-1:0] snapshot,
    input  logic [CNT_W-1:0]  byte_idx,
`ifdef READBACK_CSUM_EN
    output logic [7:0]        csum,
`endif
    output logic [7:0]        byte_out
);

    localparam int NBYTES = byte_count(DATA_W);

    // Byte selection by index, LSB byte at index 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        byte_out = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_idx == CNT_W'(b)) begin
                byte_out = snapshot[b*8 +: 8];
            end
        end
    end

`ifdef READBACK_CSUM_EN
    // XOR checksum over every snapshot byte.
    always_comb begin
        csum = '0;
        for (int b = 0; b < NBYTES; b++) begin
            csum = csum ^ snapshot[b*8 +: 8];
        end
    end
`endif

endmodule

// File: rtl/config_readback.sv
// config_readback: snapshots one configuration register on a read request
// and streams it LSB byte first through the transmitter send/busy handshake.
// Optional macro READBACK_CSUM_EN appends an XOR checksum byte.
import config_readback_pkg::*;

module config_readback #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       rd_req,
    input  logic [REG_IDX_W-1:0]       rd_sel,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic                       rd_busy,
    output logic                       rd_done,
    output logic                       rd_err
);

    localparam int              NBYTES = byte_count(DATA_W);
    localparam int              CNT_W  = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES - 1);

    rb_state_t         state;
    logic [DATA_W-1:0] snapshot;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sel_word;
    logic              sel_ok;
    logic [7:0]        next_byte;
`ifdef READBACK_CSUM_EN
    logic [7:0]        csum;
`endif

    // Pick the requested register out of the flattened bank.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_sel == REG_IDX_W'(k)) begin
                sel_word = reg_bank[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ok = (int'(rd_sel) < NUM_REGS);

    readback_byte_mux #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_byte_mux (
        .snapshot (snapshot),
        .byte_idx (cnt + CNT_W'(1)),
`ifdef READBACK_CSUM_EN
        .csum     (csum),
`endif
        .byte_out (next_byte)
    );

    // Readback FSM; tx_data only moves on entry or on an accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state    <= ST_IDLE;
            snapshot <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_send  <= 1'b0;
            rd_busy  <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        if (sel_ok) begin
                            snapshot <= sel_word;
                            cnt      <= '0;
                            tx_data  <= sel_word[7:0];
                            tx_send  <= 1'b1;
                            rd_busy  <= 1'b1;
                            state    <= ST_SEND;
                        end else begin
                            rd_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        if (cnt == LAST) begin
`ifdef READBACK_CSUM_EN
                            tx_data <= csum;
                            state   <= ST_CSUM;
`else
                            tx_send <= 1'b0;
                            rd_done <= 1'b1;
                            state   <= ST_DONE;
`endif
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            tx_data <= next_byte;
                        end
                    end
                end
`ifdef READBACK_CSUM_EN
                ST_CSUM: begin
                    if (!tx_busy) begin
                        tx_send <= 1'b0;
                        rd_done <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    rd_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    tx_send <= 1'b0;
                    rd_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/config_readback.md
# config_readback

Register readback responder for the analyzer's configuration bank. The host writes configuration registers, such as the flags register, over the command interface. This block serves the opposite direction: on a read request it snapshots one selected 32-bit register and streams it to the host, byte by byte, through the UART transmitter's send/busy handshake. It sits between the configuration registers and the transmitter, beside the command decoder that issues `rd_req`.

## Interface
Parameters:
- `NUM_REGS`, 4: number of readable registers, 1..8.
- `DATA_W`, 32: register width; must be a multiple of 8.

Ports:
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: one-cycle read request strobe.
- `rd_sel` in 3: register index, sampled together with `rd_req`.
- `reg_bank` in NUM_REGS*DATA_W: flattened register values; register k occupies bits [k*DATA_W +: DATA_W]; register 0 is `flags_reg`.
- `tx_data` out 8: byte offered to the transmitter.
- `tx_send` out 1: byte-valid strobe; held high until accepted.
- `tx_busy` in 1: transmitter not ready.
- `rd_busy` out 1: high while a readback is in progress.
- `rd_done` out 1: one-cycle pulse after the last byte is accepted.
- `rd_err` out 1: one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, SEND, CSUM, DONE.
- IDLE, `rd_req`=1, `rd_sel`<NUM_REGS:
  - capture the selected register into a DATA_W snapshot;
  - byte counter := 0;
  - go to SEND.
- IDLE, `rd_req`=1, `rd_sel`>=NUM_REGS: pulse `rd_err` for one cycle; no bytes are sent; stay in IDLE.
- SEND:
  - `tx_send`=1 and `tx_data` = snapshot byte[counter], LSB byte first.
  - A byte is accepted on an edge where `tx_send`=1 and `tx_busy`=0.
  - On acceptance: counter+1. If this was the last byte (DATA_W/8-1), go to CSUM when the macro is on, else to DONE.
- CSUM (macro only): `tx_data` = XOR of all snapshot bytes, `tx_send`=1; on acceptance go to DONE.
- DONE: `rd_done`=1 for one cycle, then IDLE.
- `rd_req` outside IDLE is ignored silently: no `rd_err`, no queueing.
- The snapshot is frozen for the whole transfer; changes on `reg_bank` mid-transfer do not affect bytes sent.
- `rd_busy`=1 in SEND, CSUM and DONE.
- Byte counter width is clog2(DATA_W/8), minimum 1 bit; it never wraps inside a transfer.

## Timing
- Reset values: `tx_data`=0, `tx_send`=0, `rd_busy`=0, `rd_done`=0, `rd_err`=0, state IDLE, snapshot 0.
- `reset_n` low mid-transfer aborts immediately; no further bytes are sent.
- `rd_req` at edge N → `tx_send`=1 from cycle N+1 with byte 0.
- With `tx_busy` held 0, one byte per cycle:
  - last data byte accepted at edge N+DATA_W/8 (N+4 for 32-bit);
  - CSUM adds one cycle;
  - `rd_done` high in the following cycle.
- `tx_data` only changes on the edge that accepts a byte (or the entry edge), so it stays stable while `tx_busy`=1.
- `rd_err` is high in cycle N+1 for a rejected request at edge N.
- All outputs are registered.

## Configuration
- `READBACK_CSUM_EN` defined: a trailing XOR checksum byte follows the data bytes, giving DATA_W/8+1 bytes per transfer.
- `READBACK_CSUM_EN` undefined: the CSUM state and the XOR logic are absent; exactly DATA_W/8 bytes per transfer.

## Structure
- The shared package holds:
  - the FSM state encoding (2-bit enum IDLE/SEND/CSUM/DONE);
  - the register index constants (`REG_FLAGS`=0, …);
  - the byte-count helper function.
- One natural sub-module, `readback_byte_mux`: it selects snapshot byte[counter] and accumulates the XOR checksum. The FSM stays in the top module.

## Test plan
- Plain readback:
  - Stimulus: `reg_bank[31:0]`=0x12345678, `rd_req` with `rd_sel`=0, `tx_busy`=0.
  - Response: bytes 0x78, 0x56, 0x34, 0x12 on consecutive cycles, then `rd_done` pulse.
  - With `READBACK_CSUM_EN`: an extra byte 0x08.
- Backpressure:
  - Stimulus: `tx_busy`=1 for 5 cycles during byte 1.
  - Response: `tx_send` stays high and `tx_data` holds 0x56 until `tx_busy` falls; no byte is duplicated or skipped.
- Invalid index:
  - Stimulus: `rd_sel`=5 with NUM_REGS=4.
  - Response: `rd_err` pulses once; `tx_send` never asserts; `rd_busy` stays 0.
- Snapshot and request while busy:
  - Stimulus: change `reg_bank[31:0]` to 0xFFFFFFFF after byte 0 is accepted, and pulse `rd_req` again mid-transfer.
  - Response: remaining bytes still 0x56, 0x34, 0x12; the second request is ignored with no `rd_err`; exactly one `rd_done`.
- Reset mid-transfer:
  - Stimulus: assert `reset_n`=0 asynchronously between clock edges after byte 1.
  - Response: all outputs reach their reset values immediately; after release, a new request to register 1 streams register 1 from byte 0.
